// File: rtl/inv_stage_pkg.sv
// Shared types and helpers for the inverting skid stage: FSM state encoding,
// occupancy codes and the static inversion function.
package inv_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Widest data word apply_inv handles; callers zero-extend and truncate.
  localparam int INV_MAX_W = 64;

  function automatic logic [INV_MAX_W-1:0] apply_inv(
    input logic [INV_MAX_W-1:0] data,
    input logic [INV_MAX_W-1:0] mask
  );
    return data ^ mask;
  endfunction

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      EMPTY:   return OCC_EMPTY;
      ONE:     return OCC_ONE;
      default: return OCC_FULL;
    endcase
  endfunction

endpackage

// File: rtl/inv_skid_stage.sv
// Registered 2-entry skid stage feeding a cell with an invertible data pin;
// applies a static per-bit inversion mask and an optional active-low valid.
module inv_skid_stage
  import inv_stage_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] INV_D     = '0,
  parameter logic             INV_VALID = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_nxt;
  logic [WIDTH-1:0] d_eff;
  logic             v_eff;
  logic             acc;
  logic             emit;

  assign v_eff = in_valid ^ INV_VALID;
  assign d_eff = WIDTH'(apply_inv(INV_MAX_W'(in_data), INV_MAX_W'(INV_D)));
  assign acc   = v_eff & in_ready;
  assign emit  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (acc) begin
          main_nxt  = d_eff;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && emit) begin
          main_nxt = d_eff;
        end else if (acc) begin
          skid_nxt  = d_eff;
          state_nxt = FULL;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path exists; skid is older.
        if (emit) begin
          main_nxt  = skid;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage boundary: all outputs are registered from the next state. in_ready
  // is held low by reset, so its first rise after release doubles as the
  // ready enable and nothing is captured on that first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main      <= '0;
      skid      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      occupancy <= OCC_EMPTY;
    end else begin
      state     <= state_nxt;
      main      <= main_nxt;
      skid      <= skid_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= occ_of(state_nxt);
    end
  end

  assign out_data = main;

endmodule

// File: doc/inv_skid_stage.md
Name: inv_skid_stage

Overview:
- Registered 2-entry skid stage sitting directly upstream of a blackbox cell with an invertible multi-bit input pin.
- Applies a per-bit static inversion mask to incoming data, the same function the inverter-integration pass folds into INV_* parameters.
- Provides a valid/ready handshake on both sides and drives the downstream cell's data pin from a register.
- Used as the sequential test vehicle for inverter absorption across a pipeline boundary.

Parameters:
- WIDTH, 2, data width in bits (>=1).
- INV_D, {WIDTH{1'b0}}, per-bit inversion mask; bit i set means in_data[i] is inverted before capture.
- INV_VALID, 1'b0, when 1, in_valid is treated as active-low.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream valid; polarity set by INV_VALID.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  registered, mask-applied data.
- occupancy  output  2  number of held words, 0..2.

Behaviour:
- Definitions:
  - v_eff = in_valid ^ INV_VALID.
  - d_eff = in_data ^ INV_D.
  - acc = v_eff & in_ready.
  - emit = out_valid & out_ready.
- Reset (rst_n=0, asynchronous):
  - State EMPTY; out_valid=0, in_ready=0, out_data=0, occupancy=0.
  - Main and skid registers are cleared to 0.
- After reset release: in_ready rises on the first rising clk edge (a registered ready_en flag). No transfer is accepted on that edge.
- Registers: main (drives out_data) and skid.
- States and transitions:
  - EMPTY: acc -> main<=d_eff, go ONE (out_valid=1 next cycle; latency 1). out_ready is ignored.
  - ONE, acc & emit -> main<=d_eff, stay ONE (full throughput, 1 word/cycle).
  - ONE, acc only -> skid<=d_eff, go FULL.
  - ONE, emit only -> go EMPTY; main holds its stale value.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so acc is impossible. emit -> main<=skid, go ONE. No emit -> hold.
- Outputs:
  - in_ready = ready_en & (state != FULL), registered from next-state.
  - out_valid = (state != EMPTY), registered.
  - occupancy = 0 / 1 / 2 for EMPTY / ONE / FULL.
- Boundary cases:
  - v_eff while in_ready=0 is ignored; upstream must hold data. The stage does not sample it.
  - Simultaneous acc and emit in ONE never transitions to FULL.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Reset asserted mid-transfer discards both registers immediately. No word is emitted after reset release until a new acc.
  - Ordering is strict FIFO: skid is always older than any later capture.

Decomposition:
- Package inv_stage_pkg:
  - state enum {EMPTY, ONE, FULL}, 2-bit encoding 00/01/10.
  - Function apply_inv(data, mask) returning data ^ mask.
  - Occupancy constants.
- No sub-module is natural. The two registers and the FSM fit in one module of roughly 150 lines.

Test Plan (WIDTH=2, INV_D=2'b01, INV_VALID=0):
- Reset then idle: rst_n 0->1 -> in_ready=0 on the release cycle, =1 after the next edge. out_valid=0, occupancy=0.
- Single word: in_data=2'b10, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=2'b11. Following cycle out_valid=0.
- Backpressure: out_ready=0, send 2'b00 then 2'b11 -> out_data=2'b01, occupancy=2, in_ready=0. Third word 2'b10 is held off. Raise out_ready -> outputs 2'b01, 2'b10, 2'b11 in order.
- Streaming: out_ready=1, words 0,1,2,3 back-to-back -> outputs 1,0,3,2 on consecutive cycles, occupancy stays 1, in_ready never drops.
- Reset mid-operation: FULL with 2 words, pulse rst_n low asynchronously (between edges) -> out_valid and in_ready fall immediately, occupancy=0. No stale word appears after release.
- INV_VALID=1 variant: in_valid=0 with in_data=2'b11 -> word accepted, out_data=2'b10. in_valid=1 -> nothing accepted.
